// File: rtl/gf_mult_arbiter.sv
// gf_mult_arbiter: round-robin sharing of one digit-serial GF(2^m) multiplier among NREQ requesters
module gf_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 41,
  parameter int BW      = 163,
  parameter int CW      = 203,
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_a,
  input  logic [NREQ*BW-1:0] req_b,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [CW-1:0]      rsp_c,
  output logic               rsp_err,
  output logic               busy,
  output logic               mul_enable,
  output logic [AW-1:0]      mul_a,
  output logic [BW-1:0]      mul_b,
  input  logic [CW-1:0]      mul_c,
  input  logic               mul_done
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, FLUSH} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, owner, owner_n, sel;
  logic [TW-1:0] cnt, cnt_n;
  logic timed_out, timed_out_n, found, rsp_err_n, mul_enable_n;
  logic [NREQ-1:0] gnt_n, rsp_valid_n;
  logic [CW-1:0] rsp_c_n;
  logic [AW-1:0] mul_a_n;
  logic [BW-1:0] mul_b_n;
  // first pending requester at or after ptr; descending loop so the closest offset wins
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        sel = PW'((int'(ptr) + i) % NREQ);
        found = 1'b1;
      end
    end
  end
  // sequencer: next state plus next values of every registered output
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    cnt_n = cnt;
    timed_out_n = timed_out;
    gnt_n = '0;
    rsp_valid_n = '0;
    mul_enable_n = 1'b0;
    mul_a_n = mul_a;
    mul_b_n = mul_b;
    rsp_c_n = rsp_c;
    rsp_err_n = rsp_err;
    case (state)
      IDLE: if (found) begin
        gnt_n[sel] = 1'b1;
        mul_a_n = req_a[sel*AW +: AW];
        mul_b_n = req_b[sel*BW +: BW];
        owner_n = sel;
        state_n = LAUNCH;
      end
      LAUNCH: begin
        mul_enable_n = 1'b1;
        cnt_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = cnt + TW'(1);
        if (mul_done || cnt == TW'(TIMEOUT)) begin
          rsp_c_n = mul_done ? mul_c : '0;
          rsp_err_n = !mul_done;
          timed_out_n = !mul_done;
          rsp_valid_n[owner] = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        ptr_n = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
        cnt_n = '0;
        state_n = timed_out ? FLUSH : IDLE;
      end
      FLUSH: begin
        cnt_n = cnt + TW'(1);
        state_n = (mul_done || cnt == TW'(TIMEOUT - 1)) ? IDLE : FLUSH;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      timed_out <= 1'b0;
      gnt <= '0;
      rsp_valid <= '0;
      rsp_c <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
      mul_enable <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      cnt <= cnt_n;
      timed_out <= timed_out_n;
      gnt <= gnt_n;
      rsp_valid <= rsp_valid_n;
      rsp_c <= rsp_c_n;
      rsp_err <= rsp_err_n;
      busy <= state_n != IDLE;
      mul_enable <= mul_enable_n;
      mul_a <= mul_a_n;
      mul_b <= mul_b_n;
    end
  end
endmodule

// File: tb/tb_gf_mult_arbiter.sv
// tb_gf_mult_arbiter: directed tests against an edge-timestamp transaction model
module tb_gf_mult_arbiter;
  localparam int NREQ = 4, AW = 41, BW = 163, CW = 203, TIMEOUT = 63;
  logic clk = 0, rst = 1, rsp_err, busy, mul_enable, mul_done = 0;
  logic [NREQ-1:0] req = '0, gnt, rsp_valid, g;
  logic [NREQ*AW-1:0] req_a = '0;
  logic [NREQ*BW-1:0] req_b = '0;
  logic [CW-1:0] rsp_c, mul_c = '0;
  logic [AW-1:0] mul_a;
  logic [BW-1:0] mul_b;
  int n_chk = 0, n_fail = 0;
  int e = 0, t_gnt = -10, t_rsp = -10, m_ptr = 0, m_owner = 0;
  bit active = 0, m_err = 0;
  logic [AW-1:0] m_a = '0;
  logic [BW-1:0] m_b = '0;
  logic [CW-1:0] m_c = '0;

  gf_mult_arbiter #(.NREQ(NREQ), .AW(AW), .BW(BW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_err(rsp_err), .busy(busy),
    .mul_enable(mul_enable), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [CW-1:0] clmul(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [CW-1:0] c = '0;
    for (int i = 0; i < AW; i++) if (a[i]) c ^= CW'(b) << i;
    return c;
  endfunction

  // Model: each operation is a set of edge timestamps; outputs follow from them.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      active = 0; t_gnt = -10; t_rsp = -10; m_ptr = 0; m_owner = 0;
      m_err = 0; m_a = '0; m_b = '0; m_c = '0;
    end else begin
      e++;
      if (!active) begin
        if (req != 0) begin
          m_owner = rr_pick(req, m_ptr);
          active = 1; t_gnt = e; t_rsp = -10;
          m_a = req_a[m_owner*AW +: AW];
          m_b = req_b[m_owner*BW +: BW];
        end
      end else if (t_rsp < 0) begin
        if (e >= t_gnt + 2) begin
          if (mul_done) begin t_rsp = e; m_c = mul_c; m_err = 0; end
          else if (e == t_gnt + 2 + TIMEOUT) begin t_rsp = e; m_c = '0; m_err = 1; end
        end
      end else if (e == t_rsp + 1) begin
        m_ptr = (m_owner + 1) % NREQ;
        if (!m_err) active = 0;
      end else if (mul_done || e == t_rsp + 1 + TIMEOUT) active = 0;
    end
  end

  // Compare every output against the model on each falling edge.
  initial forever begin
    @(negedge clk);
    check("gnt", CW'(gnt), CW'((e == t_gnt) ? onehot(m_owner) : '0));
    check("mul_enable", CW'(mul_enable), CW'(e == t_gnt + 1));
    check("rsp_valid", CW'(rsp_valid), CW'((e == t_rsp) ? onehot(m_owner) : '0));
    check("rsp_c", rsp_c, m_c);
    check("rsp_err", CW'(rsp_err), CW'(m_err));
    check("busy", CW'(busy), CW'(active));
    check("mul_a", CW'(mul_a), CW'(m_a));
    check("mul_b", CW'(mul_b), CW'(m_b));
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] gg);
    int n = 0;
    while (gnt == 0 && n < 20) begin tick(); n++; end
    gg = gnt;
  endtask

  // Multiplier stand-in: wait for the enable cycle, then raise done lat cycles later.
  task automatic serve(input int lat, input bit hang);
    int n = 0;
    while (!mul_enable && n < 20) begin tick(); n++; end
    check("enable_seen", CW'(mul_enable), CW'(1));
    if (!hang && mul_enable) begin
      repeat (lat) tick();
      mul_c = clmul(mul_a, mul_b);
      mul_done = 1;
      tick();
      mul_done = 0;
      mul_c = '0;
    end
  endtask

  initial begin
    #2 rst = 0;
    tick();
    check("reset_gnt", CW'(gnt), '0);
    check("reset_busy", CW'(busy), '0);
    check("reset_mul_a", CW'(mul_a), '0);
    tick();
    rst = 1;
    // single op to requester 2
    set_op(2, 41'h1, 163'h3);
    req = 4'b0100;
    tick();
    check("t1_gnt", CW'(gnt), CW'(4'b0100));
    check("t1_mul_a", CW'(mul_a), CW'(1));
    check("t1_mul_b", CW'(mul_b), CW'(3));
    req = 4'b0000;
    tick();
    check("t1_enable", CW'(mul_enable), CW'(1));
    serve(11, 0);
    check("t1_rsp_valid", CW'(rsp_valid), CW'(4'b0100));
    check("t1_rsp_c", rsp_c, CW'(3));
    check("t1_rsp_err", CW'(rsp_err), '0);
    // pointer wrap: ptr is 3 after serving requester 2
    set_op(0, 41'h5, 163'h7);
    set_op(3, 41'h3, 163'h9);
    req = 4'b1001;
    wait_gnt(g);
    check("t3_first", CW'(g), CW'(4'b1000));
    req[3] = 0;
    serve(4, 0);
    check("t3_rsp_c", rsp_c, CW'(27));
    wait_gnt(g);
    check("t3_second", CW'(g), CW'(4'b0001));
    req[0] = 0;
    serve(5, 0);
    check("t3_rsp2_c", rsp_c, CW'(27));
    // contention from reset with all requests held
    rst = 0;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_op(i, AW'(i + 7), BW'(3 * i + 11));
    tick();
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g);
      check("t2_gnt_order", CW'(g), CW'(onehot(i % NREQ)));
      serve(2 + i, 0);
      check("t2_rsp_owner", CW'(rsp_valid), CW'(onehot(i % NREQ)));
      if (i == 4) req = 4'b0000;
    end
    // timeout: ptr is 1, requester 1 never gets done
    set_op(1, 41'h2, 163'h2);
    req = 4'b0010;
    wait_gnt(g);
    check("t4_gnt", CW'(g), CW'(4'b0010));
    req = 4'b0000;
    serve(0, 1);
    repeat (TIMEOUT) tick();
    check("t4_not_early", CW'(rsp_valid), '0);
    tick();
    check("t4_rsp_valid", CW'(rsp_valid), CW'(4'b0010));
    check("t4_rsp_err", CW'(rsp_err), CW'(1));
    check("t4_rsp_c", rsp_c, '0);
    tick();
    mul_done = 1;
    mul_c = CW'(203'h1234);
    tick();
    mul_done = 0;
    mul_c = '0;
    check("t4_flush_idle", CW'(busy), '0);
    check("t4_flush_no_rsp", CW'(rsp_valid), '0);
    tick();
    check("t4_flush_rsp_c", rsp_c, '0);
    // done on the very cycle the watchdog expires: ptr is 2, requester 0 wraps in
    set_op(0, 41'h1, 163'h5);
    req = 4'b0001;
    wait_gnt(g);
    check("t5_gnt", CW'(g), CW'(4'b0001));
    req = 4'b0000;
    serve(TIMEOUT, 0);
    check("t5_rsp_valid", CW'(rsp_valid), CW'(4'b0001));
    check("t5_rsp_err", CW'(rsp_err), '0);
    check("t5_rsp_c", rsp_c, CW'(5));
    tick();
    check("t5_no_flush", CW'(busy), '0);
    // reset in the middle of WAIT
    set_op(2, 41'h3, 163'h3);
    req = 4'b0100;
    wait_gnt(g);
    req = 4'b0000;
    repeat (3) tick();
    rst = 0;
    #1;
    check("t6_gnt", CW'(gnt), '0);
    check("t6_rsp_valid", CW'(rsp_valid), '0);
    check("t6_rsp_c", rsp_c, '0);
    check("t6_rsp_err", CW'(rsp_err), '0);
    check("t6_busy", CW'(busy), '0);
    check("t6_enable", CW'(mul_enable), '0);
    check("t6_mul_a", CW'(mul_a), '0);
    check("t6_mul_b", CW'(mul_b), '0);
    @(posedge clk);
    #1 rst = 1;
    set_op(1, 41'h1, 163'h1);
    req = 4'b0011;
    wait_gnt(g);
    check("t6_regrant", CW'(g), CW'(4'b0001));
    req = 4'b0000;
    serve(3, 0);
    check("t6_rsp_valid2", CW'(rsp_valid), CW'(4'b0001));
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
